// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline control: register tags, controller
// state encoding and the source/destination tag comparison helper.
package arm_pkg;

  localparam int unsigned RegTagW = 4;

  typedef logic [RegTagW-1:0] reg_tag_t;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

  // Tags compare raw; register 0 is an ordinary register here.
  function automatic logic src_match(reg_tag_t src1, reg_tag_t src2, logic two_src,
                                     reg_tag_t dst);
    return (src1 == dst) || (two_src && (src2 == dst));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the stall/flush controller: hazard inputs in, register
// enables and flush out.
interface hazard_ctrl_if
  import arm_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic             en_forwarding;
  logic             ignore_hazard;
  reg_tag_t         ID_src1;
  reg_tag_t         ID_src2;
  logic             ID_two_src;
  logic             EXE_wb_en;
  logic             EXE_mem_r_en;
  reg_tag_t         EXE_dst;
  logic             MEM_wb_en;
  reg_tag_t         MEM_dst;
  logic             mem_req;
  logic             mem_ready;
  logic             branch_taken;

  logic             freeze_front;
  logic             bubble_exe;
  logic             freeze_all;
  logic             flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output en_forwarding, ignore_hazard, ID_src1, ID_src2, ID_two_src, EXE_wb_en,
           EXE_mem_r_en, EXE_dst, MEM_wb_en, MEM_dst, mem_req, mem_ready, branch_taken,
    input  freeze_front, bubble_exe, freeze_all, flush, mem_timeout, stall_cycles
  );

  modport slave (
    input  en_forwarding, ignore_hazard, ID_src1, ID_src2, ID_two_src, EXE_wb_en,
           EXE_mem_r_en, EXE_dst, MEM_wb_en, MEM_dst, mem_req, mem_ready, branch_taken,
    output freeze_front, bubble_exe, freeze_all, flush, mem_timeout, stall_cycles
  );

endinterface

// File: rtl/hazard_ctrl_wait_watchdog.sv
// Counts cycles spent waiting on SRAM and raises a sticky timeout once the wait
// reaches TIMEOUT cycles without completion.
module wait_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic enter,
  input  logic waiting,
  input  logic mem_ready,
  output logic mem_timeout
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] wait_cnt_q;
  logic            timeout_q;
  logic            expire;

  assign expire      = waiting && !mem_ready && (wait_cnt_q == LastCnt);
  assign mem_timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (enter) begin
        wait_cnt_q <= '0;
      end else if (waiting && (wait_cnt_q != LastCnt)) begin
        // Holds at the last value so a very long wait cannot wrap around.
        wait_cnt_q <= wait_cnt_q + CntW'(1);
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: resolves data hazards, freezes the pipeline
// during multi-cycle SRAM accesses and squashes wrong-path work on taken branches.
module hazard_ctrl
  import arm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q;
  logic             exe_hit, mem_hit, hazard, mem_stall;
  logic             freeze_front, bubble_exe, freeze_all, flush;
  logic             mem_timeout;

  always_comb begin
    exe_hit = bus.EXE_wb_en &&
              src_match(bus.ID_src1, bus.ID_src2, bus.ID_two_src, bus.EXE_dst);
    mem_hit = bus.MEM_wb_en &&
              src_match(bus.ID_src1, bus.ID_src2, bus.ID_two_src, bus.MEM_dst);
    if (bus.en_forwarding) begin
      // Only a load in EXE, or a MEM result the bypass cannot deliver, must stall.
      hazard = (exe_hit && bus.EXE_mem_r_en) || (mem_hit && !bus.ignore_hazard);
    end else begin
      hazard = exe_hit || mem_hit;
    end
    mem_stall = bus.mem_req && !bus.mem_ready;
  end

  always_comb begin
    freeze_front = 1'b0;
    bubble_exe   = 1'b0;
    freeze_all   = 1'b0;
    flush        = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        freeze_all = 1'b1;
      end else if (bus.branch_taken) begin
        flush = 1'b1;
      end else begin
        freeze_front = hazard;
        bubble_exe   = hazard;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (mem_stall)     state_d = StMemWait;
      StMemWait: if (bus.mem_ready) state_d = StRun;
      default:                      state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      if ((freeze_all || freeze_front) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  wait_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_watchdog (
    .clk         (clk),
    .rst         (rst),
    .enter       ((state_q == StRun) && mem_stall),
    .waiting     (state_q == StMemWait),
    .mem_ready   (bus.mem_ready),
    .mem_timeout (mem_timeout)
  );

  assign bus.freeze_front = freeze_front;
  assign bus.bubble_exe   = bubble_exe;
  assign bus.freeze_all   = freeze_all;
  assign bus.flush        = flush;
  assign bus.mem_timeout  = mem_timeout;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic, each
// cycle checked against a behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

  localparam int unsigned Timeout = 4;
  localparam int unsigned CntW    = 4;
  localparam int          StallMax = (1 << CntW) - 1;

  typedef struct {
    logic            ff;
    logic            bub;
    logic            fa;
    logic            fl;
    logic            to;
    logic [CntW-1:0] sc;
  } exp_t;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CntW)) bus ();

  hazard_ctrl #(
    .TIMEOUT (Timeout),
    .CNT_W   (CntW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  // Reference state, kept in plain counters rather than any state encoding.
  bit m_waiting  = 0;
  int m_waited   = 0;
  bit m_timeout  = 0;
  int m_stalls   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("freeze_front", 32'(bus.freeze_front), 32'(e.ff));
      chk("bubble_exe",   32'(bus.bubble_exe),   32'(e.bub));
      chk("freeze_all",   32'(bus.freeze_all),   32'(e.fa));
      chk("flush",        32'(bus.flush),        32'(e.fl));
      chk("mem_timeout",  32'(bus.mem_timeout),  32'(e.to));
      chk("stall_cycles", 32'(bus.stall_cycles), 32'(e.sc));
    end
  end

  // Expected response for the current inputs, then advance the model across the edge.
  task automatic step();
    exp_t e;
    bit   a1, a2, exe_hit, mem_hit, hz, frz;
    a1 = 1;
    a2 = bus.ID_two_src;
    exe_hit = bus.EXE_wb_en && ((a1 && bus.ID_src1 == bus.EXE_dst) ||
                                (a2 && bus.ID_src2 == bus.EXE_dst));
    mem_hit = bus.MEM_wb_en && ((a1 && bus.ID_src1 == bus.MEM_dst) ||
                                (a2 && bus.ID_src2 == bus.MEM_dst));
    if (bus.en_forwarding)
      hz = (exe_hit && bus.EXE_mem_r_en) || (mem_hit && !bus.ignore_hazard);
    else
      hz = exe_hit || mem_hit;
    frz = bus.mem_req && !bus.mem_ready;

    e.fa  = rst && frz;
    e.fl  = rst && !frz && bus.branch_taken;
    e.ff  = rst && !frz && !bus.branch_taken && hz;
    e.bub = e.ff;
    e.to  = m_timeout;
    e.sc  = CntW'(m_stalls);
    q.push_back(e);

    if (!rst) begin
      m_waiting = 0; m_waited = 0; m_timeout = 0; m_stalls = 0;
    end else begin
      if ((e.fa || e.ff) && m_stalls < StallMax) m_stalls++;
      if (!m_waiting) begin
        if (frz) begin m_waiting = 1; m_waited = 0; end
      end else if (bus.mem_ready) begin
        m_waiting = 0;
      end else begin
        m_waited++;
        if (m_waited >= Timeout) m_timeout = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b1;
    bus.en_forwarding = 1'b1; bus.ignore_hazard = 1'b0;
    bus.ID_src1 = 4'd0; bus.ID_src2 = 4'd0; bus.ID_two_src = 1'b0;
    bus.EXE_wb_en = 1'b0; bus.EXE_mem_r_en = 1'b0; bus.EXE_dst = 4'd0;
    bus.MEM_wb_en = 1'b0; bus.MEM_dst = 4'd0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
    // Keep the ID sources off every destination tag by default.
    bus.ID_src1 = 4'd14; bus.ID_src2 = 4'd15; bus.EXE_dst = 4'd1; bus.MEM_dst = 4'd2;
  endtask

  task automatic load_use_setup();
    bus.en_forwarding = 1'b1;
    bus.EXE_wb_en = 1'b1; bus.EXE_mem_r_en = 1'b1; bus.EXE_dst = 4'd3; bus.ID_src1 = 4'd3;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    step();                         // reset state
    idle_inputs();
    step();

    // Load-use: one bubble, then the load sits in MEM covered by the bypass.
    load_use_setup();
    step();
    idle_inputs();
    bus.MEM_wb_en = 1'b1; bus.MEM_dst = 4'd3; bus.ID_src1 = 4'd3; bus.ignore_hazard = 1'b1;
    step();
    idle_inputs();
    step();

    // Forwarding off, MEM-stage hit on src2.
    bus.en_forwarding = 1'b0; bus.MEM_wb_en = 1'b1; bus.MEM_dst = 4'd5; bus.ID_src2 = 4'd5;
    bus.ID_two_src = 1'b0;
    step();
    bus.ID_two_src = 1'b1;
    step();
    bus.en_forwarding = 1'b1; bus.ignore_hazard = 1'b1;
    step();
    idle_inputs();

    // Four-cycle SRAM wait.
    bus.mem_req = 1'b1;
    repeat (4) step();
    bus.mem_ready = 1'b1;
    step();
    idle_inputs();
    step();

    // Branch against load-use, then branch under freeze.
    load_use_setup();
    bus.branch_taken = 1'b1;
    step();
    bus.mem_req = 1'b1;
    step();
    bus.mem_ready = 1'b1;
    step();
    idle_inputs();

    // Watchdog: ready low for six cycles, sticky afterwards.
    bus.mem_req = 1'b1;
    repeat (6) step();
    bus.mem_ready = 1'b1;
    step();
    idle_inputs();
    repeat (2) step();

    // Saturate the counter, then reset in the middle of a wait.
    bus.mem_req = 1'b1;
    repeat (20) step();
    rst = 1'b0;
    step();
    idle_inputs();
    repeat (2) step();

    for (int i = 0; i < 1500; i++) begin
      rst               = ($urandom_range(0, 99) != 0);
      bus.en_forwarding = 1'($urandom_range(0, 1));
      bus.ignore_hazard = 1'($urandom_range(0, 1));
      bus.ID_src1       = 4'($urandom_range(0, 3));
      bus.ID_src2       = 4'($urandom_range(0, 3));
      bus.ID_two_src    = 1'($urandom_range(0, 1));
      bus.EXE_wb_en     = 1'($urandom_range(0, 1));
      bus.EXE_mem_r_en  = 1'($urandom_range(0, 1));
      bus.EXE_dst       = 4'($urandom_range(0, 3));
      bus.MEM_wb_en     = 1'($urandom_range(0, 1));
      bus.MEM_dst       = 4'($urandom_range(0, 3));
      bus.mem_req       = ($urandom_range(0, 2) == 0);
      bus.mem_ready     = ($urandom_range(0, 3) == 0);
      bus.branch_taken  = ($urandom_range(0, 4) == 0);
      step();
    end

    idle_inputs();
    @(negedge clk);
    #1;
    n_total++;
    if (q.size() == 0) n_passed++;
    else $display("FAIL drain: %0d expected responses left, required 0", q.size());
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
